// File: rtl/ram4_bank.sv
// ram4_bank: four-entry register bank fed by one-hot demux strobes, with a bypassed
// registered read port, written flags, a write counter and a sticky collision flag.
module ram4_bank #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_a,
  input  logic             load_b,
  input  logic             load_c,
  input  logic             load_d,
  input  logic [WIDTH-1:0] in,
  input  logic             rd_en,
  input  logic [1:0]       rd_sel,
  input  logic             clr_err,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [3:0]       written,
  output logic [7:0]       wr_count,
  output logic             err
);
  logic [WIDTH-1:0] mem [4];
  logic [3:0] ld;
  logic one_hot, collide, hit;
  assign ld = {load_d, load_c, load_b, load_a};
  // A single set bit survives clearing the lowest set bit as zero.
  assign one_hot = (ld != 4'd0) && ((ld & (ld - 4'd1)) == 4'd0);
  assign collide = (ld != 4'd0) && !one_hot;
  assign hit = one_hot && ld[rd_sel];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      out <= '0;
      out_valid <= 1'b0;
      written <= 4'd0;
      wr_count <= 8'd0;
      err <= 1'b0;
    end else begin
      if (one_hot) begin
        for (int i = 0; i < 4; i++) if (ld[i]) mem[i] <= in;
        written <= written | ld;
        wr_count <= wr_count + 8'd1;
      end
      err <= collide ? 1'b1 : clr_err ? 1'b0 : err;
      if (rd_en) out <= hit ? in : mem[rd_sel];
      out_valid <= rd_en && (hit || written[rd_sel]);
    end
  end
endmodule

// File: tb/tb_ram4_bank.sv
// tb_ram4_bank: directed vector table, corner-case sequences and random stimulus
// checked against a behavioural model of the bank.
module tb_ram4_bank;
  logic clk = 0, reset = 1;
  logic load_a = 0, load_b = 0, load_c = 0, load_d = 0;
  logic [15:0] in = 0;
  logic rd_en = 0, clr_err = 0;
  logic [1:0] rd_sel = 0;
  logic [15:0] out;
  logic out_valid, err;
  logic [3:0] written;
  logic [7:0] wr_count;
  int total = 0, bad = 0;

  ram4_bank #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .load_a(load_a), .load_b(load_b), .load_c(load_c),
    .load_d(load_d), .in(in), .rd_en(rd_en), .rd_sel(rd_sel), .clr_err(clr_err),
    .out(out), .out_valid(out_valid), .written(written), .wr_count(wr_count), .err(err)
  );

  always #5 clk = ~clk;

  logic [15:0] m [4];
  logic [3:0] mw;
  int mc;
  logic me, mov;
  logic [15:0] mo;

  typedef struct {
    logic [3:0] ld; logic [15:0] din; logic rd; logic [1:0] sel; logic clr;
    logic [15:0] eo; logic ev; logic [3:0] ew; logic [7:0] ec; logic ee;
  } vec_t;
  vec_t tv [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m[i] = 0;
    mw = 0; mc = 0; me = 0; mo = 0; mov = 0;
  endtask

  // Reference behaviour of one rising edge, from the current input values.
  task automatic model_edge();
    logic [3:0] l;
    int n, k;
    l = {load_d, load_c, load_b, load_a};
    n = $countones(l);
    k = 0;
    for (int i = 0; i < 4; i++) if (l[i]) k = i;
    if (rd_en) begin
      if (n == 1 && k == int'(rd_sel)) begin mo = in; mov = 1; end
      else begin mo = m[rd_sel]; mov = mw[rd_sel]; end
    end else mov = 0;
    if (n == 1) begin m[k] = in; mw[k] = 1; mc = (mc + 1) % 256; end
    if (n >= 2) me = 1; else if (clr_err) me = 0;
  endtask

  task automatic drive(input logic [3:0] l, input logic [15:0] d, input logic r,
                       input logic [1:0] s, input logic c);
    {load_d, load_c, load_b, load_a} = l;
    in = d; rd_en = r; rd_sel = s; clr_err = c;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string nm);
    chk({nm, ".out"}, out, mo);
    chk({nm, ".out_valid"}, out_valid, mov);
    chk({nm, ".written"}, written, mw);
    chk({nm, ".wr_count"}, wr_count, mc[7:0]);
    chk({nm, ".err"}, err, me);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    reset = 1;
    model_reset();
    #1;
    chk("reset.out", out, 0);
    chk("reset.out_valid", out_valid, 0);
    chk("reset.written", written, 0);
    chk("reset.wr_count", wr_count, 0);
    chk("reset.err", err, 0);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    tv[0] = '{4'b0010, 16'h1234, 0, 0, 0, 16'h0000, 0, 4'b0010, 1, 0};
    tv[1] = '{4'b0000, 16'h0000, 1, 1, 0, 16'h1234, 1, 4'b0010, 1, 0};
    tv[2] = '{4'b0100, 16'hAAAA, 0, 0, 0, 16'h1234, 0, 4'b0110, 2, 0};
    tv[3] = '{4'b0100, 16'h5555, 1, 2, 0, 16'h5555, 1, 4'b0110, 3, 0};
    tv[4] = '{4'b1001, 16'hFFFF, 1, 0, 0, 16'h0000, 0, 4'b0110, 3, 1};
    tv[5] = '{4'b1001, 16'hFFFF, 1, 3, 1, 16'h0000, 0, 4'b0110, 3, 1};
    tv[6] = '{4'b0000, 16'h0000, 1, 2, 1, 16'h5555, 1, 4'b0110, 3, 0};
    tv[7] = '{4'b0000, 16'h0000, 1, 1, 0, 16'h1234, 1, 4'b0110, 3, 0};
    tv[8] = '{4'b0000, 16'h0000, 0, 0, 0, 16'h1234, 0, 4'b0110, 3, 0};
    tv[9] = '{4'b0001, 16'h0BEE, 1, 1, 0, 16'h1234, 1, 4'b0111, 4, 0};
    #2;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(tv[i].ld, tv[i].din, tv[i].rd, tv[i].sel, tv[i].clr);
      tick();
      chk($sformatf("vec%0d.out", i), out, tv[i].eo);
      chk($sformatf("vec%0d.out_valid", i), out_valid, tv[i].ev);
      chk($sformatf("vec%0d.written", i), written, tv[i].ew);
      chk($sformatf("vec%0d.wr_count", i), wr_count, tv[i].ec);
      chk($sformatf("vec%0d.err", i), err, tv[i].ee);
    end
    // Collision must leave entries 0 and 3 untouched.
    drive(0, 0, 1, 3, 0); tick();
    chk("coll.mem3.out", out, 16'h0000);
    chk("coll.mem3.valid", out_valid, 0);
    drive(0, 0, 1, 0, 0); tick();
    chk("coll.mem0.out", out, 16'h0BEE);

    do_reset();
    drive(0, 0, 1, 3, 0); tick();
    chk("unwritten.out", out, 0);
    chk("unwritten.valid", out_valid, 0);

    do_reset();
    for (int i = 0; i < 256; i++) begin
      drive(4'b0001 << (i % 4), 16'(i), 0, 0, 0);
      tick();
    end
    chk("wrap.wr_count", wr_count, 8'd0);
    chk("wrap.written", written, 4'b1111);
    check_model("wrap");

    drive(4'b0001, 16'h7777, 1, 2, 0);
    #2;
    reset = 1;
    model_reset();
    #1;
    chk("async.out", out, 0);
    chk("async.out_valid", out_valid, 0);
    chk("async.written", written, 0);
    chk("async.wr_count", wr_count, 0);
    chk("async.err", err, 0);
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    drive(0, 0, 1, 0, 0); tick();
    chk("async.nowrite.out", out, 0);
    chk("async.nowrite.valid", out_valid, 0);
    chk("async.nowrite.written", written, 0);
    chk("async.nowrite.wr_count", wr_count, 0);

    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [3:0] l;
      int r;
      r = $urandom_range(0, 9);
      l = r < 3 ? 4'd0 : r < 8 ? 4'b0001 << $urandom_range(0, 3) : 4'($urandom);
      drive(l, 16'($urandom), 1'($urandom), 2'($urandom), $urandom_range(0, 7) == 0);
      tick();
      check_model($sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
